// File: rtl/dec_scan_nx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dec_scan_nx_if                                             |
// | Purpose : Bundle of control inputs and decode outputs for            |
// |           dec_scan_nx.                                               |
// |   en    : block enable (master -> slave)                             |
// |   mode  : 0 manual, 1 auto-scan (master -> slave)                    |
// |   sel   : manual index / scan start index (master -> slave)          |
// |   presc : scan dwell minus one (master -> slave)                     |
// |   D     : registered one-hot (or one-cold) select (slave -> master)  |
// |   idx   : index currently driven on D (slave -> master)              |
// |   wrap  : one-cycle pulse on scan rollover max -> 0 (slave -> master)|
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface dec_scan_nx_if #(
  parameter int SEL_W   = 2,
  parameter int PRESC_W = 16
);
  logic                  en;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [PRESC_W-1:0]    presc;
  logic [(1<<SEL_W)-1:0] D;
  logic [SEL_W-1:0]      idx;
  logic                  wrap;

  modport master (
    output en, mode, sel, presc,
    input  D, idx, wrap
  );

  modport slave (
    input  en, mode, sel, presc,
    output D, idx, wrap
  );
endinterface
`default_nettype wire

// File: rtl/dec_scan_nx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dec_scan_nx                                                |
// | Purpose : Registered N-to-2^N one-hot decoder with enable, output    |
// |           polarity and an auto-scan mode (programmable prescaler,    |
// |           wrap strobe) for digit / row select lines.                 |
// | Ports   : clk   - rising-edge clock                                  |
// |           rst_n - asynchronous active-low reset                      |
// |           bus   - dec_scan_nx_if.slave (en, mode, sel, presc in;     |
// |                   D, idx, wrap out)                                  |
// | Options : `define DEC_SCAN_BLANK_EN inserts a one-cycle BLANK state  |
// |           before every scan index advance (anti-ghosting).           |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dec_scan_nx #(
  parameter int SEL_W      = 2,
  parameter int PRESC_W    = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  wire           clk,
  input  wire           rst_n,
  dec_scan_nx_if.slave  bus
);

  localparam int OUT_W = 1 << SEL_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MANUAL = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
`ifdef DEC_SCAN_BLANK_EN
  localparam logic [1:0] ST_BLANK  = 2'd3;
`endif

  // Inactive output pattern: all zeros, or all ones for one-cold outputs.
  localparam logic [OUT_W-1:0] D_OFF = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  localparam logic [SEL_W-1:0]   IDX_ONE = 1;
  localparam logic [SEL_W-1:0]   IDX_MAX = {SEL_W{1'b1}};
  localparam logic [PRESC_W-1:0] CNT_ONE = 1;

  logic [1:0]         state_q, state_d;
  logic [SEL_W-1:0]   idx_q,   idx_d;
  logic [PRESC_W-1:0] cnt_q,   cnt_d;
  logic [OUT_W-1:0]   d_q,     d_d;
  logic               wrap_q,  wrap_d;

  logic [SEL_W-1:0]   idx_inc;

  // Polarity is folded in before the flop so D comes straight off a register.
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  always_comb begin
    idx_inc = idx_q + IDX_ONE;

    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    wrap_d  = 1'b0;

    if (!bus.en) begin
      // Disable wins over everything else; idx and count are frozen so a
      // later re-enable in scan mode resumes where it left off.
      state_d = ST_IDLE;
      d_d     = D_OFF;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.mode) begin
            state_d = ST_SCAN;
            d_d     = decode(idx_q);
          end else begin
            state_d = ST_MANUAL;
            idx_d   = bus.sel;
            d_d     = decode(bus.sel);
          end
        end

        ST_MANUAL: begin
          // Entering scan also reloads the start index from sel.
          idx_d = bus.sel;
          d_d   = decode(bus.sel);
          if (bus.mode) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
          end
        end

        ST_SCAN: begin
          if (!bus.mode) begin
            state_d = ST_MANUAL;
            idx_d   = bus.sel;
            d_d     = decode(bus.sel);
            cnt_d   = '0;
          end else if (cnt_q == bus.presc) begin
            // Equality compare: lowering presc below the running count lets
            // the counter run to its natural rollover before matching.
            cnt_d = '0;
`ifdef DEC_SCAN_BLANK_EN
            state_d = ST_BLANK;
            d_d     = D_OFF;
`else
            idx_d  = idx_inc;
            d_d    = decode(idx_inc);
            wrap_d = (idx_q == IDX_MAX);
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

`ifdef DEC_SCAN_BLANK_EN
        ST_BLANK: begin
          if (!bus.mode) begin
            state_d = ST_MANUAL;
            idx_d   = bus.sel;
            d_d     = decode(bus.sel);
            cnt_d   = '0;
          end else begin
            // wrap lines up with the new index 0, not with the blank cycle.
            state_d = ST_SCAN;
            idx_d   = idx_inc;
            d_d     = decode(idx_inc);
            wrap_d  = (idx_q == IDX_MAX);
            cnt_d   = '0;
          end
        end
`endif

        default: begin
          state_d = ST_IDLE;
          d_d     = D_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      d_q     <= D_OFF;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.D    = d_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_scan_nx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dec_scan_nx                                             |
// | Purpose : Directed self-checking bench for dec_scan_nx (default      |
// |           build), with a second ACTIVE_LOW=1 instance sharing the    |
// |           same inputs for polarity checks.                           |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_dec_scan_nx;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  dec_scan_nx_if #(.SEL_W(2), .PRESC_W(16)) bus ();
  dec_scan_nx_if #(.SEL_W(2), .PRESC_W(16)) bus_lo ();

  assign bus_lo.en    = bus.en;
  assign bus_lo.mode  = bus.mode;
  assign bus_lo.sel   = bus.sel;
  assign bus_lo.presc = bus.presc;

  dec_scan_nx #(.SEL_W(2), .PRESC_W(16), .ACTIVE_LOW(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  dec_scan_nx #(.SEL_W(2), .PRESC_W(16), .ACTIVE_LOW(1)) dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_d;
    int         exp_i;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.en    = 1'b0;
    bus.mode  = 1'b0;
    bus.sel   = 2'd0;
    bus.presc = 16'd0;

    step();
    step();
    check("rst_D",    {28'd0, bus.D},    32'h0);
    check("rst_idx",  {30'd0, bus.idx},  32'h0);
    check("rst_wrap", {31'd0, bus.wrap}, 32'h0);
    check("rst_Dlo",  {28'd0, bus_lo.D}, 32'hF);

    // Manual decode, 1-cycle latency.
    rst_n    = 1'b1;
    bus.en   = 1'b1;
    bus.mode = 1'b0;
    bus.sel  = 2'd2;
    step();
    check("man_sel2_D",    {28'd0, bus.D},    32'h4);
    check("man_sel2_idx",  {30'd0, bus.idx},  32'h2);
    check("man_sel2_wrap", {31'd0, bus.wrap}, 32'h0);
    check("man_sel2_Dlo",  {28'd0, bus_lo.D}, 32'hB);
    bus.sel = 2'd3;
    step();
    check("man_sel3_D",   {28'd0, bus.D},   32'h8);
    check("man_sel3_idx", {30'd0, bus.idx}, 32'h3);
    bus.sel = 2'd0;
    step();
    check("man_sel0_D",   {28'd0, bus.D},    32'h1);
    check("man_sel0_Dlo", {28'd0, bus_lo.D}, 32'hE);

    // Scan from sel=1 with presc=2: dwell of 3 cycles per index.
    bus.sel = 2'd1;
    step();
    bus.mode  = 1'b1;
    bus.presc = 16'd2;
    step();
    for (int k = 0; k < 12; k++) begin
      if (k != 0) step();
      exp_i = (1 + k / 3) % 4;
      exp_d = 4'b0001 << exp_i;
      check($sformatf("scan3_D_k%0d", k),    {28'd0, bus.D},    {28'd0, exp_d});
      check($sformatf("scan3_idx_k%0d", k),  {30'd0, bus.idx},  exp_i);
      check($sformatf("scan3_wrap_k%0d", k), {31'd0, bus.wrap}, (k == 9) ? 32'h1 : 32'h0);
    end

    // Back through manual (clears prescaler) then scan with presc=0.
    bus.mode = 1'b0;
    bus.sel  = 2'd0;
    step();
    bus.mode  = 1'b1;
    bus.presc = 16'd0;
    step();
    for (int k = 0; k < 9; k++) begin
      if (k != 0) step();
      exp_i = k % 4;
      exp_d = 4'b0001 << exp_i;
      check($sformatf("scan1_D_k%0d", k),    {28'd0, bus.D},    {28'd0, exp_d});
      check($sformatf("scan1_wrap_k%0d", k), {31'd0, bus.wrap}, (k == 4 || k == 8) ? 32'h1 : 32'h0);
    end

    // presc=3, count 0 at this point: idx reaches 1 after 4 cycles.
    bus.presc = 16'd3;
    step();
    step();
    step();
    step();
    check("p3_adv_idx", {30'd0, bus.idx}, 32'h1);
    step();  // count now 1

    // Disable mid-scan: outputs inactive, idx and count held.
    bus.en = 1'b0;
    step();
    check("dis_D",   {28'd0, bus.D},   32'h0);
    check("dis_idx", {30'd0, bus.idx}, 32'h1);
    check("dis_Dlo", {28'd0, bus_lo.D}, 32'hF);
    step();
    check("dis2_D",   {28'd0, bus.D},   32'h0);
    check("dis2_idx", {30'd0, bus.idx}, 32'h1);

    // Re-enable: resume idx 1 with count 1, so two more dwell cycles.
    bus.en = 1'b1;
    step();
    check("reen_D0", {28'd0, bus.D}, 32'h2);
    step();
    check("reen_D1", {28'd0, bus.D}, 32'h2);
    step();
    check("reen_D2", {28'd0, bus.D}, 32'h2);
    step();
    check("reen_D3", {28'd0, bus.D}, 32'h4);
    check("reen_idx3", {30'd0, bus.idx}, 32'h2);

    // Asynchronous reset between clock edges.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_D",    {28'd0, bus.D},    32'h0);
    check("arst_idx",  {30'd0, bus.idx},  32'h0);
    check("arst_wrap", {31'd0, bus.wrap}, 32'h0);
    check("arst_Dlo",  {28'd0, bus_lo.D}, 32'hF);
    bus.presc = 16'd0;
    step();
    rst_n = 1'b1;
    step();
    check("post_D0",    {28'd0, bus.D},    32'h1);
    check("post_wrap0", {31'd0, bus.wrap}, 32'h0);
    step();
    check("post_D1",    {28'd0, bus.D},    32'h2);
    check("post_wrap1", {31'd0, bus.wrap}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dec_scan_nx.md
Name: dec_scan_nx

Overview:
- Parametrised, registered N-to-2^N one-hot decoder.
- Successor to the combinational 2-to-4 decoder.
- Adds enable, output polarity, and an auto-scan mode with a programmable prescaler and wrap strobe.
- Drives display-digit / row select lines, either from a manual index or by cycling through all outputs autonomously.

Parameters:
- SEL_W, 2: select width; output count is 2^SEL_W.
- PRESC_W, 16: prescaler counter width.
- ACTIVE_LOW, 0: 1 inverts D (one-cold output, all-ones when inactive).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; 0 forces all outputs inactive.
- mode  input  1  0 = manual (decode sel), 1 = auto-scan.
- sel  input  SEL_W  manual select index; also the scan start index.
- presc  input  PRESC_W  scan dwell = presc+1 clock cycles per index.
- D  output  2^SEL_W  registered one-hot decode (polarity per ACTIVE_LOW).
- idx  output  SEL_W  index currently driven on D.
- wrap  output  1  one-cycle pulse when scan index rolls from max to 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, D all inactive (0, or all-ones if ACTIVE_LOW), idx=0, wrap=0, prescaler count=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, MANUAL, SCAN (plus BLANK when the optional feature is compiled in).
- Any state with en=0 -> IDLE next cycle. In IDLE: D inactive, wrap=0, idx and prescaler hold.
- IDLE with en=1: mode=0 -> MANUAL; mode=1 -> SCAN.
- MANUAL:
  - Each cycle idx<=sel and D<=decode(sel). Latency is 1 cycle from sel to D.
  - wrap is held 0.
  - mode=1 -> SCAN. On entry, idx<=sel, prescaler count<=0, D<=decode(sel).
- SCAN:
  - Prescaler increments each cycle.
  - When count==presc: count<=0 and idx<=idx+1, modulo 2^SEL_W (natural wrap, no saturation).
  - D tracks idx with no extra latency beyond the register.
  - wrap=1 for exactly the one cycle in which idx becomes 0 from 2^SEL_W-1.
  - presc=0: idx advances every cycle.
  - presc changed mid-dwell: the compare uses the new value immediately. If count already exceeds the new presc, count continues up to the PRESC_W-bit rollover and then matches. This behaviour is accepted and documented, not corrected.
  - mode=0 -> MANUAL. D<=decode(sel) next cycle; the prescaler clears.
- Exactly one D bit is active in MANUAL and SCAN. Zero bits are active in IDLE and BLANK.
- Simultaneous events: en=0 overrides mode changes and prescaler terminal count. Reset overrides everything.
- Reset mid-scan: immediate return to reset values. After release, no wrap pulse is generated spuriously.

Optional Feature:
- Macro DEC_SCAN_BLANK_EN.
- Defined:
  - In SCAN, each index advance first enters BLANK for one cycle. In BLANK, D is inactive and idx holds the old value.
  - The cycle after BLANK, idx and D update to the new index and the state returns to SCAN.
  - Prescaler restarts at 0 on leaving BLANK, so each index period is presc+2 cycles.
  - wrap asserts on the cycle the new index 0 is driven, not during BLANK.
  - en=0 during BLANK -> IDLE.
  - The purpose is to suppress ghosting on multiplexed displays.
- Not defined: no BLANK state; behaviour exactly as above.

Test Plan:
- Reset, then release with en=1, mode=0, sel=2 -> one cycle later D=4'b0100, idx=2, wrap=0. Drive sel=3 -> next cycle D=4'b1000.
- en=1, mode=1, sel=1, presc=2 -> sequence:
  - D=0010 for 3 cycles, then 0100 for 3, 1000 for 3, then 0001.
  - wrap=1 only on the first cycle of 0001.
- presc=0 in scan -> D rotates 0001, 0010, 0100, 1000, 0001 on consecutive cycles; wrap=1 every 4th cycle.
- Mid-scan en=0 -> D=0000 next cycle with idx held. Re-enable -> scan resumes from the held idx with prescaler at held count.
- Assert rst_n=0 asynchronously between clock edges during scan -> D=0000, idx=0 without waiting for a clock edge.
- ACTIVE_LOW=1 build, manual sel=0 -> D=4'b1110. With DEC_SCAN_BLANK_EN and presc=1, scan shows 1110,1110,1111,1101,1101,1111,...
